// File: rtl/patch_bus_arbiter_if.sv
// Patch-parameter bus bundle shared by the arbiter and its neighbours.
//   master : the arbiter side (drives strobes, selects, ack/dump status, TX byte)
//   slave  : the environment side (MIDI decoder requests, sysex TX ready,
//            parameter-block read-back on bus_din)
// Signals:
//   wr_req/wr_bank/wr_adr/wr_data -> wr_ack   single-parameter write request
//   dump_start -> dump_busy/dump_done         full patch dump control
//   tx_valid/tx_data <-> tx_ready             dump byte stream to sysex TX
//   bus_adr/bus_dout/bus_oe/bus_din           parameter bus address and data
//   bus_write (active low) / bus_read         bus strobes
//   sysex_data_patch_send                     read-back driver enable
//   osc_sel/com_sel/m1_sel/m2_sel             one-hot bank selects
interface patch_bus_arbiter_if;
    logic       wr_req;
    logic [1:0] wr_bank;
    logic [6:0] wr_adr;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic       dump_start;
    logic       dump_busy;
    logic       dump_done;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic [6:0] bus_adr;
    logic [7:0] bus_dout;
    logic       bus_oe;
    logic [7:0] bus_din;
    logic       bus_write;
    logic       bus_read;
    logic       sysex_data_patch_send;
    logic       osc_sel;
    logic       com_sel;
    logic       m1_sel;
    logic       m2_sel;

    modport master (
        input  wr_req, wr_bank, wr_adr, wr_data, dump_start, tx_ready, bus_din,
        output wr_ack, dump_busy, dump_done, tx_valid, tx_data,
               bus_adr, bus_dout, bus_oe, bus_write, bus_read,
               sysex_data_patch_send, osc_sel, com_sel, m1_sel, m2_sel
    );

    modport slave (
        output wr_req, wr_bank, wr_adr, wr_data, dump_start, tx_ready, bus_din,
        input  wr_ack, dump_busy, dump_done, tx_valid, tx_data,
               bus_adr, bus_dout, bus_oe, bus_write, bus_read,
               sysex_data_patch_send, osc_sel, com_sel, m1_sel, m2_sel
    );
endinterface

// File: rtl/patch_bus_arbiter.sv
// Owner of the shared patch-parameter bus. Arbitrates single-parameter writes
// from the MIDI/sysex decoder against a sequenced full-patch dump that reads
// every bank/address back and streams the bytes to the sysex transmitter.
// Ports:
//   sCLK_XVXENVS  clock, all logic on posedge
//   iRST_N        asynchronous active-low reset
//   bus           patch_bus_arbiter_if.master (requests, dump control,
//                 TX valid/ready stream, bus strobes, bank selects)
module patch_bus_arbiter #(
    parameter int WR_LOW   = 2,
    parameter int RD_WAIT  = 2,
    parameter int BANKS    = 4,
    parameter int DUMP_LEN = 128
) (
    input  logic                sCLK_XVXENVS,
    input  logic                iRST_N,
    patch_bus_arbiter_if.master bus
);
    localparam int CNT_MAX = (WR_LOW > RD_WAIT) ? WR_LOW : RD_WAIT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_LOW - 1);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_WAIT - 1);
    localparam logic [1:0]       BANK_LAST = 2'(BANKS - 1);
    localparam logic [6:0]       ADR_LAST  = 7'(DUMP_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_SETUP,
        S_WR_STROBE,
        S_WR_HOLD,
        S_RD_SETUP,
        S_RD_STROBE,
        S_RD_WAIT,
        S_TX
    } state_t;

    state_t           state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [1:0]       wr_bank_q,    wr_bank_d;
    logic [6:0]       wr_adr_q,     wr_adr_d;
    logic [7:0]       wr_data_q,    wr_data_d;
    logic [1:0]       ptr_bank_q,   ptr_bank_d;
    logic [6:0]       ptr_adr_q,    ptr_adr_d;
    logic             pending_q,    pending_d;
    logic             busy_q,       busy_d;
    logic             dump_first_q, dump_first_d;
    logic             ack_q,        ack_d;
    logic             done_q,       done_d;
    logic [7:0]       tx_data_q,    tx_data_d;

    logic             last_item;
    logic             wr_phase;
    logic             rd_phase;
    logic [1:0]       sel_bank;

    // State register
    always_ff @(posedge sCLK_XVXENVS or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            wr_bank_q    <= '0;
            wr_adr_q     <= '0;
            wr_data_q    <= '0;
            ptr_bank_q   <= '0;
            ptr_adr_q    <= '0;
            pending_q    <= 1'b0;
            busy_q       <= 1'b0;
            dump_first_q <= 1'b0;
            ack_q        <= 1'b0;
            done_q       <= 1'b0;
            tx_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_bank_q    <= wr_bank_d;
            wr_adr_q     <= wr_adr_d;
            wr_data_q    <= wr_data_d;
            ptr_bank_q   <= ptr_bank_d;
            ptr_adr_q    <= ptr_adr_d;
            pending_q    <= pending_d;
            busy_q       <= busy_d;
            dump_first_q <= dump_first_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
            tx_data_q    <= tx_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_bank_d    = wr_bank_q;
        wr_adr_d     = wr_adr_q;
        wr_data_d    = wr_data_q;
        ptr_bank_d   = ptr_bank_q;
        ptr_adr_d    = ptr_adr_q;
        pending_d    = pending_q;
        busy_d       = busy_q;
        dump_first_d = dump_first_q;
        ack_d        = 1'b0;
        done_d       = 1'b0;
        tx_data_d    = tx_data_q;
        last_item    = (ptr_bank_q == BANK_LAST) && (ptr_adr_q == ADR_LAST);

        // Pointer and pending are only touched here while no dump runs, so
        // this never collides with the TX-state updates below.
        if (bus.dump_start && !busy_q) begin
            busy_d     = 1'b1;
            pending_d  = 1'b1;
            ptr_bank_d = '0;
            ptr_adr_d  = '0;
        end

        case (state_q)
            S_IDLE: begin
                // Under contention the flag alternates the winner; a lone
                // requester always wins.
                if (bus.wr_req && (!pending_q || !dump_first_q)) begin
                    state_d   = S_WR_SETUP;
                    ack_d     = 1'b1;
                    wr_bank_d = bus.wr_bank;
                    wr_adr_d  = bus.wr_adr;
                    wr_data_d = bus.wr_data;
                end else if (pending_q) begin
                    state_d   = S_RD_SETUP;
                    pending_d = 1'b0;
                end
            end
            S_WR_SETUP: begin
                state_d = S_WR_STROBE;
                cnt_d   = '0;
            end
            S_WR_STROBE: begin
                if (cnt_q == WR_LAST) begin
                    state_d = S_WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WR_HOLD: begin
                state_d      = S_IDLE;
                dump_first_d = 1'b1;
            end
            S_RD_SETUP: begin
                state_d = S_RD_STROBE;
            end
            S_RD_STROBE: begin
                state_d = S_RD_WAIT;
                cnt_d   = '0;
            end
            S_RD_WAIT: begin
                if (cnt_q == RD_LAST) begin
                    state_d   = S_TX;
                    tx_data_d = bus.bus_din;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_TX: begin
                if (bus.tx_ready) begin
                    state_d      = S_IDLE;
                    dump_first_d = 1'b0;
                    if (ptr_adr_q == ADR_LAST) begin
                        ptr_adr_d  = '0;
                        ptr_bank_d = (ptr_bank_q == BANK_LAST) ? 2'd0 : ptr_bank_q + 1'b1;
                    end else begin
                        ptr_adr_d = ptr_adr_q + 1'b1;
                    end
                    if (last_item) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        pending_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        wr_phase = (state_q == S_WR_SETUP) || (state_q == S_WR_STROBE) || (state_q == S_WR_HOLD);
        rd_phase = (state_q == S_RD_SETUP) || (state_q == S_RD_STROBE) || (state_q == S_RD_WAIT);
        sel_bank = wr_phase ? wr_bank_q : ptr_bank_q;

        bus.osc_sel               = (wr_phase || rd_phase) && (sel_bank == 2'd0);
        bus.com_sel               = (wr_phase || rd_phase) && (sel_bank == 2'd1);
        bus.m1_sel                = (wr_phase || rd_phase) && (sel_bank == 2'd2);
        bus.m2_sel                = (wr_phase || rd_phase) && (sel_bank == 2'd3);
        bus.bus_adr               = wr_phase ? wr_adr_q : (rd_phase ? ptr_adr_q : '0);
        bus.bus_dout              = wr_phase ? wr_data_q : '0;
        bus.bus_oe                = wr_phase;
        bus.bus_write             = (state_q != S_WR_STROBE);
        bus.bus_read              = (state_q == S_RD_STROBE);
        bus.sysex_data_patch_send = rd_phase;
        bus.tx_valid              = (state_q == S_TX);
        bus.tx_data               = tx_data_q;
        bus.wr_ack                = ack_q;
        bus.dump_busy             = busy_q;
        bus.dump_done             = done_q;
    end
endmodule

// File: tb/tb_patch_bus_arbiter.sv
// Self-checking bench for patch_bus_arbiter: write waveform table, full dump,
// contention alternation, TX stall, mid-operation resets, random traffic.
module tb_patch_bus_arbiter;
    localparam int WR_LOW   = 2;
    localparam int RD_WAIT  = 2;
    localparam int BANKS    = 4;
    localparam int DUMP_LEN = 128;
    localparam int TOTAL    = BANKS * DUMP_LEN;

    logic sCLK_XVXENVS = 1'b0;
    logic iRST_N       = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    patch_bus_arbiter_if pif ();

    patch_bus_arbiter #(
        .WR_LOW   (WR_LOW),
        .RD_WAIT  (RD_WAIT),
        .BANKS    (BANKS),
        .DUMP_LEN (DUMP_LEN)
    ) dut (
        .sCLK_XVXENVS (sCLK_XVXENVS),
        .iRST_N       (iRST_N),
        .bus          (pif)
    );

    always #5 sCLK_XVXENVS = ~sCLK_XVXENVS;

    // Parameter-block read-back model: byte = {bank, adr[5:0]}
    logic [3:0] sels;
    logic [1:0] sel_bank;
    assign sels = {pif.m2_sel, pif.m1_sel, pif.com_sel, pif.osc_sel};
    always_comb begin
        sel_bank = 2'd0;
        for (int i = 0; i < 4; i++) if (sels[i]) sel_bank = 2'(i);
    end
    assign pif.bus_din = {sel_bank, pif.bus_adr[5:0]};

    typedef struct packed {
        logic [1:0] bank;
        logic [6:0] adr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [1:0] bank;
        logic [6:0] adr;
        logic [7:0] data;
        logic [3:0] exp_sel;
    } vec_t;

    wr_t exp_wr[$];
    wr_t cur_w;
    byte op_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int idx);
        int b;
        int a;
        b = idx / DUMP_LEN;
        a = idx % DUMP_LEN;
        return {2'(b), 6'(a)};
    endfunction

    // ---------------- monitor + high-level reference model ----------------
    logic       oe_prev, send_prev, txv_prev, txr_prev;
    logic [7:0] txd_prev;
    int         wr_len, low_len, send_len;
    int         m_idx, bytes_acc, dut_dones;
    logic       m_busy, m_done_next, busy_now;

    always @(negedge sCLK_XVXENVS) begin
        if (!iRST_N) begin
            oe_prev = 0; send_prev = 0; txv_prev = 0; txr_prev = 0; txd_prev = '0;
            wr_len = 0; low_len = 0; send_len = 0;
            m_idx = 0; m_busy = 0; m_done_next = 0;
        end else begin
            chk("sel_onehot", 64'($countones(sels)), (pif.bus_oe || pif.sysex_data_patch_send) ? 64'd1 : 64'd0);
            chk("oe_during_read", 64'(pif.bus_oe && (pif.bus_read || pif.sysex_data_patch_send)), 64'd0);
            chk("strobe_outside_write", 64'(!pif.bus_write && !pif.bus_oe), 64'd0);
            chk("wr_ack_pulse", 64'(pif.wr_ack), 64'(pif.bus_oe && !oe_prev));

            if (pif.bus_oe && !oe_prev) begin
                op_log.push_back("W");
                wr_len = 0;
                low_len = 0;
                if (exp_wr.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
                else cur_w = exp_wr.pop_front();
            end
            if (pif.bus_oe) begin
                wr_len++;
                if (!pif.bus_write) low_len++;
                chk("wr_bus", {sels, pif.bus_adr, pif.bus_dout},
                    {4'b0001 << cur_w.bank, cur_w.adr, cur_w.data});
            end
            if (!pif.bus_oe && oe_prev) begin
                chk("wr_len", 64'(wr_len), 64'(WR_LOW + 2));
                chk("wr_low_len", 64'(low_len), 64'(WR_LOW));
            end

            if (pif.sysex_data_patch_send && !send_prev) op_log.push_back("R");
            if (pif.sysex_data_patch_send) send_len = send_prev ? send_len + 1 : 1;
            if (pif.tx_valid && !txv_prev) chk("rd_latency", 64'(send_len), 64'(2 + RD_WAIT));
            if (txv_prev && !txr_prev) begin
                chk("tx_hold_valid", 64'(pif.tx_valid), 64'd1);
                chk("tx_hold_data", 64'(pif.tx_data), 64'(txd_prev));
            end

            if (pif.dump_done) dut_dones++;
            chk("dump_busy", 64'(pif.dump_busy), 64'(m_busy));
            chk("dump_done", 64'(pif.dump_done), 64'(m_done_next));
            busy_now = m_busy;
            m_done_next = 0;
            if (pif.tx_valid && pif.tx_ready) begin
                chk("tx_data", 64'(pif.tx_data), 64'(exp_byte(m_idx)));
                m_idx++;
                bytes_acc++;
                if (m_idx == TOTAL) begin
                    m_busy = 0;
                    m_done_next = 1;
                end
            end
            if (pif.dump_start && !busy_now) begin
                m_busy = 1;
                m_idx = 0;
            end

            oe_prev = pif.bus_oe;
            send_prev = pif.sysex_data_patch_send;
            txv_prev = pif.tx_valid;
            txr_prev = pif.tx_ready;
            txd_prev = pif.tx_data;
        end
    end

    // ---------------- helpers ----------------
    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"},
            {pif.wr_ack, pif.dump_busy, pif.dump_done, pif.tx_valid, pif.bus_oe,
             pif.bus_write, pif.bus_read, pif.sysex_data_patch_send, sels},
            {4'b0000, 1'b0, 1'b1, 2'b00, 4'b0000});
        chk({tag, "_data"}, {pif.tx_data, pif.bus_adr, pif.bus_dout}, 64'd0);
    endtask

    task automatic apply_reset();
        iRST_N = 1'b0;
        pif.wr_req = 1'b0;
        pif.dump_start = 1'b0;
        pif.tx_ready = 1'b0;
        exp_wr.delete();
        repeat (2) @(posedge sCLK_XVXENVS);
        #1;
        iRST_N = 1'b1;
    endtask

    task automatic pulse_dump();
        pif.dump_start = 1'b1;
        @(posedge sCLK_XVXENVS);
        #1;
        pif.dump_start = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the ack cycle.
    task automatic do_write(input logic [1:0] b, input logic [6:0] a, input logic [7:0] d);
        int  n;
        bit  seen;
        wr_t w;
        pif.wr_bank = b;
        pif.wr_adr = a;
        pif.wr_data = d;
        pif.wr_req = 1'b1;
        w = {b, a, d};
        exp_wr.push_back(w);
        seen = 0;
        for (n = 0; n < 200 && !seen; n++) begin
            @(negedge sCLK_XVXENVS);
            seen = pif.wr_ack;
        end
        chk("write_acked", 64'(seen), 64'd1);
        @(posedge sCLK_XVXENVS);
        #1;
        pif.wr_req = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 0;
        for (int n = 0; n < 8000 && !seen; n++) begin
            @(negedge sCLK_XVXENVS);
            seen = pif.dump_done;
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        @(posedge sCLK_XVXENVS);
        #1;
    endtask

    // ---------------- test sequence ----------------
    vec_t vec[5];
    logic active;
    bit   seen;
    bit   req_active;
    int   req_wait;
    int   dones0;
    wr_t  w;

    initial begin
        pif.wr_req = 1'b0;
        pif.wr_bank = '0;
        pif.wr_adr = '0;
        pif.wr_data = '0;
        pif.dump_start = 1'b0;
        pif.tx_ready = 1'b0;

        vec[0] = '{bank: 2'd2, adr: 7'h13, data: 8'h55, exp_sel: 4'b0100};
        vec[1] = '{bank: 2'd0, adr: 7'h00, data: 8'hA5, exp_sel: 4'b0001};
        vec[2] = '{bank: 2'd1, adr: 7'h00, data: 8'hFF, exp_sel: 4'b0010};
        vec[3] = '{bank: 2'd3, adr: 7'h7F, data: 8'h00, exp_sel: 4'b1000};
        vec[4] = '{bank: 2'd1, adr: 7'h40, data: 8'h3C, exp_sel: 4'b0010};

        // Reset state
        #2;
        check_reset_outputs("reset");
        apply_reset();

        // Write waveform table: t counts negedges from the request cycle
        foreach (vec[i]) begin
            pif.wr_bank = vec[i].bank;
            pif.wr_adr = vec[i].adr;
            pif.wr_data = vec[i].data;
            pif.wr_req = 1'b1;
            w = {vec[i].bank, vec[i].adr, vec[i].data};
            exp_wr.push_back(w);
            for (int t = 0; t <= WR_LOW + 3; t++) begin
                @(negedge sCLK_XVXENVS);
                active = (t >= 1) && (t <= WR_LOW + 2);
                chk($sformatf("vec%0d_t%0d_ctl", i, t),
                    {pif.wr_ack, pif.bus_write, pif.bus_oe, sels},
                    {t == 1, !(t >= 2 && t <= WR_LOW + 1), active, active ? vec[i].exp_sel : 4'b0000});
                if (active)
                    chk($sformatf("vec%0d_t%0d_bus", i, t), {pif.bus_adr, pif.bus_dout},
                        {vec[i].adr, vec[i].data});
                @(posedge sCLK_XVXENVS);
                #1;
                if (t == 1) pif.wr_req = 1'b0;
            end
        end

        // Full dump, dump_start re-pulsed while busy must be ignored
        pif.tx_ready = 1'b1;
        bytes_acc = 0;
        dones0 = dut_dones;
        pulse_dump();
        repeat (60) @(posedge sCLK_XVXENVS);
        #1;
        pulse_dump();
        wait_done("dump1");
        repeat (5) @(posedge sCLK_XVXENVS);
        #1;
        chk("dump1_bytes", 64'(bytes_acc), 64'(TOTAL));
        chk("dump1_done_pulses", 64'(dut_dones - dones0), 64'd1);

        // Contention: writes held back-to-back during a dump alternate with reads
        apply_reset();
        pif.tx_ready = 1'b1;
        op_log.delete();
        bytes_acc = 0;
        pulse_dump();
        do_write(2'd1, 7'h11, 8'h21);
        do_write(2'd2, 7'h22, 8'h42);
        do_write(2'd3, 7'h33, 8'h63);
        wait_done("dump2");
        chk("alt_log_len", 64'(op_log.size() >= 6), 64'd1);
        if (op_log.size() >= 6)
            for (int k = 0; k < 6; k++)
                chk($sformatf("alt_op%0d", k), 64'(op_log[k]), (k % 2 == 0) ? 64'("W") : 64'("R"));
        chk("dump2_bytes", 64'(bytes_acc), 64'(TOTAL));

        // TX stall with a pending write
        apply_reset();
        pif.tx_ready = 1'b0;
        pulse_dump();
        seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge sCLK_XVXENVS);
            seen = pif.tx_valid;
        end
        chk("stall_tx_valid_seen", 64'(seen), 64'd1);
        @(posedge sCLK_XVXENVS);
        #1;
        pif.wr_bank = 2'd0;
        pif.wr_adr = 7'h05;
        pif.wr_data = 8'h9E;
        pif.wr_req = 1'b1;
        w = {2'd0, 7'h05, 8'h9E};
        exp_wr.push_back(w);
        for (int n = 0; n < 10; n++) begin
            @(negedge sCLK_XVXENVS);
            chk("stall_no_ack", 64'(pif.wr_ack), 64'd0);
            chk("stall_valid", 64'(pif.tx_valid), 64'd1);
            chk("stall_data", 64'(pif.tx_data), 64'(exp_byte(0)));
            @(posedge sCLK_XVXENVS);
            #1;
        end
        pif.tx_ready = 1'b1;
        seen = 0;
        for (int n = 0; n < 6 && !seen; n++) begin
            @(negedge sCLK_XVXENVS);
            seen = pif.wr_ack;
        end
        chk("stall_ack_after_accept", 64'(seen), 64'd1);
        chk("stall_one_byte", 64'(m_idx), 64'd1);
        @(posedge sCLK_XVXENVS);
        #1;
        pif.wr_req = 1'b0;

        // Reset in the middle of RD_WAIT
        seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge sCLK_XVXENVS);
            seen = pif.bus_read;
        end
        chk("rdwait_strobe_seen", 64'(seen), 64'd1);
        @(negedge sCLK_XVXENVS);
        #1;
        iRST_N = 1'b0;
        #1;
        check_reset_outputs("rst_rdwait");
        apply_reset();

        // Reset in the middle of WR_STROBE, then a fresh dump from (0,0)
        pif.wr_bank = 2'd3;
        pif.wr_adr = 7'h2A;
        pif.wr_data = 8'h77;
        pif.wr_req = 1'b1;
        w = {2'd3, 7'h2A, 8'h77};
        exp_wr.push_back(w);
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge sCLK_XVXENVS);
            seen = !pif.bus_write;
        end
        chk("wrstrobe_seen", 64'(seen), 64'd1);
        #1;
        iRST_N = 1'b0;
        #1;
        check_reset_outputs("rst_wrstrobe");
        apply_reset();
        pif.tx_ready = 1'b1;
        bytes_acc = 0;
        pulse_dump();
        wait_done("dump3");
        chk("dump3_bytes", 64'(bytes_acc), 64'(TOTAL));

        // Random traffic against the model
        req_active = 0;
        req_wait = 0;
        for (int c = 0; c < 4000; c++) begin
            if (!req_active && $urandom_range(0, 4) == 0) begin
                pif.wr_bank = 2'($urandom_range(0, 3));
                pif.wr_adr = 7'($urandom_range(0, 127));
                pif.wr_data = 8'($urandom_range(0, 255));
                pif.wr_req = 1'b1;
                w = {pif.wr_bank, pif.wr_adr, pif.wr_data};
                exp_wr.push_back(w);
                req_active = 1;
                req_wait = 0;
            end
            pif.dump_start = ($urandom_range(0, 80) == 0);
            pif.tx_ready = ($urandom_range(0, 1) == 1);
            @(negedge sCLK_XVXENVS);
            if (req_active) begin
                if (pif.wr_ack) req_active = 0;
                else begin
                    req_wait++;
                    if (req_wait == 2000) chk("rand_ack_timeout", 64'd1, 64'd0);
                end
            end
            @(posedge sCLK_XVXENVS);
            #1;
            if (!req_active) pif.wr_req = 1'b0;
        end

        // Drain
        pif.dump_start = 1'b0;
        pif.tx_ready = 1'b1;
        for (int n = 0; n < 8000 && (req_active || pif.dump_busy); n++) begin
            @(negedge sCLK_XVXENVS);
            if (req_active && pif.wr_ack) req_active = 0;
            @(posedge sCLK_XVXENVS);
            #1;
            if (!req_active) pif.wr_req = 1'b0;
        end
        chk("drain_idle", 64'(req_active || pif.dump_busy), 64'd0);
        repeat (10) @(posedge sCLK_XVXENVS);
        #1;
        chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d miscompares %0d", vectors, miscompares);
        $fatal(1, "watchdog");
    end
endmodule
